// File: rtl/soc_sysid_checker.sv
// Boot-time system-ID checker: reads ID and timestamp words over Avalon-MM and
// compares them to build-time constants; pass releases the CPU, fail flags an error.
// Ports:
//   clock, reset (async, active-high), start
//   avm_address, avm_read, avm_waitrequest, avm_readdata (Avalon-MM read master)
//   busy, done, pass, fail, id_value, ts_value, retry_count
//   timeout (only when SYSID_CHK_TIMEOUT_EN is defined)
// Optional feature macro: SYSID_CHK_TIMEOUT_EN adds a waitrequest watchdog.
module soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1766428251,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned MAX_RETRY      = 2,
  parameter bit          AUTO_START     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_count
`ifdef SYSID_CHK_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_WT_ID, S_RD_TS, S_WT_TS, S_CMP, S_DONE
  } state_t;

  localparam bit       LAT0 = (READ_LATENCY == 0);
  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  localparam logic [3:0] MAXR = 4'(MAX_RETRY);

  state_t     state, next_state;
  logic       first_q;
  logic [2:0] lat_cnt;
  logic       go, accept, lat_hit, match, retry_ok;
  logic       cap_id, cap_ts, to_hit;

  // first_q marks the first cycle after reset release for auto-start
  assign go       = start || (AUTO_START && first_q);
  assign accept   = avm_read && !avm_waitrequest;
  assign lat_hit  = (lat_cnt == LAT);
  assign match    = (id_value == EXPECTED_ID) &&
                    (ts_value == EXPECTED_TS);
  assign retry_ok = (retry_count < MAXR);
  assign cap_id   = (state == S_RD_ID && accept && LAT0) ||
                    (state == S_WT_ID && lat_hit);
  assign cap_ts   = (state == S_RD_TS && accept && LAT0) ||
                    (state == S_WT_TS && lat_hit);

`ifdef SYSID_CHK_TIMEOUT_EN
  logic [15:0] stall_cnt;
  assign to_hit = avm_read && avm_waitrequest &&
                  (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Restarts on every read strobe; a stall past the limit aborts the run
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        stall_cnt <= '0;
    else if (!avm_read || accept)     stall_cnt <= '0;
    else                              stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (go) next_state = S_RD_ID;
      S_RD_ID: begin
        if (to_hit)      next_state = S_DONE;
        else if (accept) next_state = LAT0 ? S_RD_TS : S_WT_ID;
      end
      S_WT_ID: if (lat_hit) next_state = S_RD_TS;
      S_RD_TS: begin
        if (to_hit)      next_state = S_DONE;
        else if (accept) next_state = LAT0 ? S_CMP : S_WT_TS;
      end
      S_WT_TS: if (lat_hit) next_state = S_CMP;
      S_CMP: begin
        if (match)         next_state = S_DONE;
        else if (retry_ok) next_state = S_RD_ID;
        else               next_state = S_DONE;
      end
      S_DONE:  if (go) next_state = S_RD_ID;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    avm_read    = (state == S_RD_ID) || (state == S_RD_TS);
    avm_address = (state == S_RD_TS) || (state == S_WT_TS);
    busy        = (state != S_IDLE) && (state != S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_q     <= 1'b1;
      lat_cnt     <= '0;
      id_value    <= '0;
      ts_value    <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      retry_count <= '0;
`ifdef SYSID_CHK_TIMEOUT_EN
      timeout     <= 1'b0;
`endif
    end else begin
      first_q <= 1'b0;
      // acceptance cycle is count 0
      if (accept)
        lat_cnt <= 3'd1;
      else if (state == S_WT_ID || state == S_WT_TS)
        lat_cnt <= lat_cnt + 3'd1;
      if (cap_id) id_value <= avm_readdata;
      if (cap_ts) ts_value <= avm_readdata;
      if ((state == S_IDLE || state == S_DONE) && go) begin
        done        <= 1'b0;
        pass        <= 1'b0;
        fail        <= 1'b0;
        retry_count <= '0;
`ifdef SYSID_CHK_TIMEOUT_EN
        timeout     <= 1'b0;
`endif
      end
      if (state == S_CMP) begin
        if (match) begin
          pass <= 1'b1;
          done <= 1'b1;
        end else if (retry_ok) begin
          retry_count <= retry_count + 4'd1;
        end else begin
          fail <= 1'b1;
          done <= 1'b1;
        end
      end
      if (to_hit) begin
        fail <= 1'b1;
        done <= 1'b1;
`ifdef SYSID_CHK_TIMEOUT_EN
        timeout <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Directed bench for soc_sysid_checker: one zero-latency instance (a) and one
// latency-2 instance with a stalling slave (b).
module tb_soc_sysid_checker;

  localparam logic [31:0] GOOD_TS = 32'd1766428251;
  localparam logic [31:0] BAD_TS  = 32'd1766428250;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel, base;

  // instance a
  logic        start_a, addr_a, read_a, wr_a;
  logic [31:0] rd_a, sid_a, sts_a, id_a, tsv_a;
  logic        busy_a, done_a, pass_a, fail_a;
  logic [3:0]  rc_a;
  int          nrd_a = 0;

  // instance b
  logic        start_b, addr_b, read_b, wr_b;
  logic [31:0] rd_b, id_b, tsv_b;
  logic        busy_b, done_b, pass_b, fail_b;
  logic [3:0]  rc_b;
  int          nrd_b = 0;
  int          stall_b;
  logic        v1, v2;
  logic [31:0] d1, d2;
  logic        held = 1'b0;
  logic        haddr = 1'b0;
  int          addr_bad = 0;
  int          nstall_b = 0;

`ifdef SYSID_CHK_TIMEOUT_EN
  logic to_a, to_b;
`endif

  soc_sysid_checker #(
    .READ_LATENCY(0), .TIMEOUT_CYCLES(10)
  ) u_a (
    .clock(clock), .reset(reset), .start(start_a),
    .avm_address(addr_a), .avm_read(read_a),
    .avm_waitrequest(wr_a), .avm_readdata(rd_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
    .id_value(id_a), .ts_value(tsv_a), .retry_count(rc_a)
`ifdef SYSID_CHK_TIMEOUT_EN
    , .timeout(to_a)
`endif
  );

  soc_sysid_checker #(
    .READ_LATENCY(2)
  ) u_b (
    .clock(clock), .reset(reset), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b),
    .avm_waitrequest(wr_b), .avm_readdata(rd_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
    .id_value(id_b), .ts_value(tsv_b), .retry_count(rc_b)
`ifdef SYSID_CHK_TIMEOUT_EN
    , .timeout(to_b)
`endif
  );

  assign rd_a = addr_a ? sts_a : sid_a;

  // slave b: 3 stall cycles per read, data valid 2 cycles after accept
  assign wr_b = read_b && (stall_b != 3);
  assign rd_b = v2 ? d2 : 32'hDEADBEEF;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_b <= 0;
      v1 <= 1'b0; v2 <= 1'b0;
      d1 <= '0;   d2 <= '0;
    end else begin
      stall_b <= (read_b && wr_b) ? stall_b + 1 : 0;
      v1 <= read_b && !wr_b;
      d1 <= addr_b ? GOOD_TS : 32'd0;
      v2 <= v1;
      d2 <= d1;
    end
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (read_a && !wr_a) nrd_a <= nrd_a + 1;
    if (read_b && !wr_b) nrd_b <= nrd_b + 1;
  end

  always @(negedge clock) begin
    if (held && read_b && addr_b != haddr) addr_bad <= addr_bad + 1;
    if (read_b && wr_b) nstall_b <= nstall_b + 1;
    held  <= read_b && wr_b;
    haddr <= addr_b;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a(int n);
    for (int i = 0; i < n && !done_a; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_b(int n);
    for (int i = 0; i < n && !done_b; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic pulse_a();
    @(negedge clock) start_a = 1'b1;
    @(negedge clock) start_a = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    wr_a = 1'b0; sid_a = 32'd0; sts_a = GOOD_TS;
    #1;
    chk("rst_flags_a", {busy_a, done_a, pass_a, fail_a}, 0);
    chk("rst_bus_a", {read_a, addr_a}, 0);
    chk("rst_vals_a", id_a | tsv_a | 32'(rc_a), 0);

    // 1: auto-start, latency 0 -> done 4 edges after release
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    rel = cyc;
    repeat (3) @(posedge clock);
    #1 chk("t1_done_early", done_a, 0);
    @(posedge clock);
    #1 chk("t1_done", done_a, 1);
    chk("t1_pass", {pass_a, fail_a, busy_a}, 3'b100);
    chk("t1_retry", rc_a, 0);
    chk("t1_ts", tsv_a, GOOD_TS);

    // 2: latency 2 with 3-cycle stalls
    wait_b(60);
    chk("t2_done", done_b, 1);
    chk("t2_cycles", cyc - rel, 14);
    chk("t2_pass", {pass_b, fail_b}, 2'b10);
    chk("t2_vals", {id_b, tsv_b}, {32'd0, GOOD_TS});
    chk("t2_addr_stable", addr_bad, 0);
    chk("t2_stalls", nstall_b, 6);

    // 3: timestamp always wrong -> 3 read pairs then fail
    sts_a = BAD_TS;
    base = nrd_a;
    pulse_a();
    wait_a(60);
    chk("t3_done", done_a, 1);
    chk("t3_flags", {pass_a, fail_a}, 2'b01);
    chk("t3_retry", rc_a, 2);
    chk("t3_ts", tsv_a, BAD_TS);
    chk("t3_reads", nrd_a - base, 6);

    // 4: first ts wrong, second right
    pulse_a();
    chk("t4_clear", {done_a, pass_a, fail_a, busy_a}, 4'b0001);
    chk("t4_clear_rc", rc_a, 0);
    for (int i = 0; i < 20 && !(read_a && addr_a); i++)
      @(negedge clock);
    @(posedge clock);
    #1 sts_a = GOOD_TS;
    wait_a(60);
    chk("t4_pass", {done_a, pass_a, fail_a}, 3'b110);
    chk("t4_retry", rc_a, 1);
    pulse_a();
    chk("t4_rerun_clear", {done_a, pass_a, busy_a}, 3'b001);
    chk("t4_rerun_rc", rc_a, 0);
    wait_a(60);
    chk("t4_rerun", {done_a, pass_a, rc_a}, {2'b11, 4'd0});

    // 5: reset in WT_TS, then start while busy
    @(negedge clock) start_b = 1'b1;
    @(negedge clock) start_b = 1'b0;
    for (int i = 0; i < 40 && !(busy_b && !read_b && addr_b); i++)
      @(negedge clock);
    chk("t5_in_wt_ts", {busy_b, read_b, addr_b}, 3'b101);
    reset = 1'b1;
    #1;
    chk("t5_rst_flags", {busy_b, done_b, pass_b, fail_b}, 0);
    chk("t5_rst_bus", {read_b, addr_b}, 0);
    chk("t5_rst_vals", id_b | tsv_b | 32'(rc_b), 0);
    @(negedge clock) reset = 1'b0;
    base = nrd_b;
    repeat (3) @(negedge clock);
    chk("t5_busy", busy_b, 1);
    start_b = 1'b1;
    @(negedge clock) start_b = 1'b0;
    wait_b(60);
    repeat (20) @(negedge clock);
    chk("t5_once", {done_b, pass_b, busy_b}, 3'b110);
    chk("t5_reads", nrd_b - base, 2);

    // 6: waitrequest stuck
    wait_a(20);
    wr_a = 1'b1;
    pulse_a();
`ifdef SYSID_CHK_TIMEOUT_EN
    repeat (9) @(posedge clock);
    #1 chk("t6_pre", {busy_a, to_a, read_a}, 3'b101);
    @(posedge clock);
    #1 chk("t6_to", {done_a, fail_a, to_a, read_a}, 4'b1110);
    chk("t6_rc", rc_a, 0);
    wr_a = 1'b0;
    pulse_a();
    chk("t6_to_clr", to_a, 0);
`else
    repeat (300) @(posedge clock);
    #1 chk("t6_stuck", {busy_a, read_a, done_a}, 3'b110);
    wr_a = 1'b0;
`endif
    wait_a(60);
    chk("t6_recover", {done_a, pass_a}, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
